// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and default tuning constants for the fetch/data memory port arbiter.
package mem_arb_pkg;

   typedef enum logic [1:0] {IDLE, IBUSY, DBUSY} arb_state_t;

   localparam int unsigned TIMEOUT_DEF  = 16;
   localparam int unsigned FAIR_MAX_DEF = 4;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Single-port memory bus between the arbiter (master) and the unified memory (slave).
interface mem_port_arbiter_if #(
   parameter int unsigned AW = 32,
   parameter int unsigned DW = 32
);

   logic          mem_req;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;
   logic          mem_ack;

   modport master (
      output mem_req, mem_we, mem_addr, mem_wdata,
      input  mem_rdata, mem_ack
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdata,
      output mem_rdata, mem_ack
   );

endinterface

// File: rtl/mem_port_arbiter_sat_counter.sv
// Up-counter with synchronous clear (dominant) that holds at MAX instead of wrapping.
module sat_counter #(
   parameter int unsigned W   = 4,
   parameter int unsigned MAX = 15
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_en,
   input  logic         i_clr,
   output logic [W-1:0] o_cnt
);

   logic [W-1:0] r_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_en && (r_cnt != W'(MAX))) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_cnt = r_cnt;

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one unified memory between fetch (F) and memory (M) stages with data
// priority, a fetch-starvation bound and a watchdog that aborts unacknowledged accesses.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned AW       = 32,
   parameter int unsigned DW       = 32,
   parameter int unsigned TIMEOUT  = TIMEOUT_DEF,
   parameter int unsigned FAIR_MAX = FAIR_MAX_DEF
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      IReqF,
   input  logic [AW-1:0]             PCF,
   output logic [DW-1:0]             InstrF,
   output logic                      IReadyF,
   input  logic                      DReqM,
   input  logic                      MemWriteM,
   input  logic [AW-1:0]             ALUOutM,
   input  logic [DW-1:0]             WriteDataM,
   output logic [DW-1:0]             ReadDataM,
   output logic                      DReadyM,
   output logic                      StallF,
   output logic                      StallM,
   output logic                      BusErr,
   mem_port_arbiter_if.master        mem
);

   localparam int unsigned WD_W = $clog2(TIMEOUT);
   localparam int unsigned FR_W = $clog2(FAIR_MAX + 1);

   arb_state_t    r_state, w_state_nxt;
   logic          r_req, w_req_nxt;
   logic          r_we, w_we_nxt;
   logic [AW-1:0] r_addr, w_addr_nxt;
   logic [DW-1:0] r_wdata, w_wdata_nxt;

   logic [WD_W-1:0] w_wdog;
   logic [FR_W-1:0] w_fair;
   logic w_idle, w_busy, w_ack, w_abort, w_done;
   logic w_fair_full, w_grant_f, w_grant_d;

   assign w_idle      = (r_state == IDLE);
   assign w_busy      = (r_state == IBUSY) || (r_state == DBUSY);
   assign w_ack       = w_busy & mem.mem_ack;
   assign w_abort     = w_busy & ~mem.mem_ack & (w_wdog == WD_W'(TIMEOUT - 1));
   assign w_done      = w_ack | w_abort;
   assign w_fair_full = (w_fair == FR_W'(FAIR_MAX));
   assign w_grant_f   = w_idle & IReqF & (~DReqM | w_fair_full);
   assign w_grant_d   = w_idle & DReqM & ~w_grant_f;

   // Watchdog counts unacknowledged busy cycles; cleared whenever an access ends.
   sat_counter #(.W(WD_W), .MAX(TIMEOUT - 1)) u_wdog (
      .clk   (clk),
      .rst   (reset),
      .i_en  (w_busy & ~mem.mem_ack),
      .i_clr (~w_busy | w_done),
      .o_cnt (w_wdog)
   );

   // Fairness counts data grants that bypassed a waiting fetch.
   sat_counter #(.W(FR_W), .MAX(FAIR_MAX)) u_fair (
      .clk   (clk),
      .rst   (reset),
      .i_en  (w_grant_d & IReqF),
      .i_clr (w_grant_f | (w_grant_d & ~IReqF)),
      .o_cnt (w_fair)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
         r_req   <= 1'b0;
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_req   <= w_req_nxt;
         r_we    <= w_we_nxt;
         r_addr  <= w_addr_nxt;
         r_wdata <= w_wdata_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_req_nxt   = r_req;
      w_we_nxt    = r_we;
      w_addr_nxt  = r_addr;
      w_wdata_nxt = r_wdata;
      case (r_state)
         IDLE: begin
            if (w_grant_f) begin
               w_state_nxt = IBUSY;
               w_req_nxt   = 1'b1;
               w_we_nxt    = 1'b0;
               w_addr_nxt  = PCF;
            end else if (w_grant_d) begin
               w_state_nxt = DBUSY;
               w_req_nxt   = 1'b1;
               w_we_nxt    = MemWriteM;
               w_addr_nxt  = ALUOutM;
               w_wdata_nxt = WriteDataM;
            end
         end
         IBUSY, DBUSY: begin
            if (w_done) begin
               w_state_nxt = IDLE;
               w_req_nxt   = 1'b0;
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_req_nxt   = 1'b0;
         end
      endcase
   end

   assign IReadyF   = (r_state == IBUSY) & w_done;
   assign DReadyM   = (r_state == DBUSY) & w_done;
   assign InstrF    = ((r_state == IBUSY) && mem.mem_ack) ? mem.mem_rdata : '0;
   assign ReadDataM = ((r_state == DBUSY) && mem.mem_ack) ? mem.mem_rdata : '0;
   assign StallF    = IReqF & ~IReadyF;
   assign StallM    = DReqM & ~DReadyM;
   assign BusErr    = w_abort;

   assign mem.mem_req   = r_req;
   assign mem.mem_we    = r_we;
   assign mem.mem_addr  = r_addr;
   assign mem.mem_wdata = r_wdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench: fetch/data agents push expected results on issue, pop on Ready;
// a bus monitor checks grant order and field stability against an expected grant list.
module tb_mem_port_arbiter;

   localparam int unsigned AW       = 32;
   localparam int unsigned DW       = 32;
   localparam int unsigned TIMEOUT  = 16;
   localparam int unsigned FAIR_MAX = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          IReqF;
   logic [AW-1:0] PCF;
   logic [DW-1:0] InstrF;
   logic          IReadyF;
   logic          DReqM;
   logic          MemWriteM;
   logic [AW-1:0] ALUOutM;
   logic [DW-1:0] WriteDataM;
   logic [DW-1:0] ReadDataM;
   logic          DReadyM;
   logic          StallF;
   logic          StallM;
   logic          BusErr;

   mem_port_arbiter_if #(.AW(AW), .DW(DW)) u_mem ();

   mem_port_arbiter #(
      .AW       (AW),
      .DW       (DW),
      .TIMEOUT  (TIMEOUT),
      .FAIR_MAX (FAIR_MAX)
   ) u_dut (
      .clk        (clk),
      .reset      (reset),
      .IReqF      (IReqF),
      .PCF        (PCF),
      .InstrF     (InstrF),
      .IReadyF    (IReadyF),
      .DReqM      (DReqM),
      .MemWriteM  (MemWriteM),
      .ALUOutM    (ALUOutM),
      .WriteDataM (WriteDataM),
      .ReadDataM  (ReadDataM),
      .DReadyM    (DReadyM),
      .StallF     (StallF),
      .StallM     (StallM),
      .BusErr     (BusErr),
      .mem        (u_mem)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [DW-1:0] data;
      logic          berr;
      int unsigned   lat;
   } exp_t;

   typedef struct {
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
   } acc_t;

   logic [AW-1:0] f_stim[$];
   acc_t          d_stim[$];
   exp_t          f_exp[$];
   exp_t          d_exp[$];
   acc_t          g_exp[$];

   int unsigned n_vec = 0;
   int unsigned n_err = 0;
   int unsigned cyc   = 0;
   int unsigned rsp_lat = 1;
   int unsigned exp_lat = 0;
   bit          exp_berr = 1'b0;
   bit          late_ack = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [DW-1:0] memval(input logic [AW-1:0] a);
      if (a == 32'h0000_0008) return 32'hE280_2001;
      return {a[15:0] ^ 16'hA5C3, ~a[15:0]};
   endfunction

   function automatic acc_t mk(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd);
      acc_t r;
      r.we = we; r.addr = a; r.wdata = wd;
      return r;
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // Memory model: acks in busy cycle rsp_lat (0 = never); junk data otherwise.
   initial begin
      int unsigned bcnt;
      bcnt = 0;
      u_mem.mem_ack   = 1'b0;
      u_mem.mem_rdata = '0;
      forever begin
         @(posedge clk); #1;
         if (u_mem.mem_req) begin
            bcnt++;
            if (rsp_lat != 0 && bcnt == rsp_lat) begin
               u_mem.mem_ack   = 1'b1;
               u_mem.mem_rdata = memval(u_mem.mem_addr);
            end else begin
               u_mem.mem_ack   = 1'b0;
               u_mem.mem_rdata = 32'hBAD0_0000 | bcnt;
            end
         end else begin
            bcnt = 0;
            u_mem.mem_ack   = late_ack;
            u_mem.mem_rdata = late_ack ? 32'h1234_5678 : '0;
         end
      end
   end

   // Fetch agent
   initial begin
      bit done;
      int unsigned t0;
      exp_t e;
      IReqF = 1'b0; PCF = '0; done = 1'b0; t0 = 0;
      forever begin
         @(negedge clk);
         if (IReqF && !done && !reset) begin
            if (IReadyF) begin
               check("F_pending", 32'(f_exp.size()), 32'd1);
               if (f_exp.size() != 0) begin
                  e = f_exp.pop_front();
                  check("InstrF", InstrF, e.data);
                  check("F_BusErr", 32'(BusErr), 32'(e.berr));
                  check("StallF_ready", 32'(StallF), 32'd0);
                  if (e.lat != 0) check("F_latency", cyc - t0 + 1, e.lat);
               end
               done = 1'b1;
            end else begin
               check("StallF_wait", 32'(StallF), 32'd1);
            end
         end
         @(posedge clk); #1;
         if (reset) begin
            IReqF = 1'b0; done = 1'b0; f_exp.delete();
         end else begin
            if (done) begin IReqF = 1'b0; done = 1'b0; end
            if (!IReqF && f_stim.size() != 0) begin
               PCF    = f_stim.pop_front();
               IReqF  = 1'b1;
               t0     = cyc;
               e.data = exp_berr ? '0 : memval(PCF);
               e.berr = exp_berr;
               e.lat  = exp_lat;
               f_exp.push_back(e);
            end
         end
      end
   end

   // Data agent
   initial begin
      bit done;
      int unsigned t0;
      exp_t e;
      acc_t a;
      DReqM = 1'b0; MemWriteM = 1'b0; ALUOutM = '0; WriteDataM = '0;
      done = 1'b0; t0 = 0;
      forever begin
         @(negedge clk);
         if (DReqM && !done && !reset) begin
            if (DReadyM) begin
               check("D_pending", 32'(d_exp.size()), 32'd1);
               if (d_exp.size() != 0) begin
                  e = d_exp.pop_front();
                  check("ReadDataM", ReadDataM, e.data);
                  check("D_BusErr", 32'(BusErr), 32'(e.berr));
                  check("StallM_ready", 32'(StallM), 32'd0);
                  if (e.lat != 0) check("D_latency", cyc - t0 + 1, e.lat);
               end
               done = 1'b1;
            end else begin
               check("StallM_wait", 32'(StallM), 32'd1);
            end
         end
         @(posedge clk); #1;
         if (reset) begin
            DReqM = 1'b0; done = 1'b0; d_exp.delete();
         end else begin
            if (done) begin DReqM = 1'b0; done = 1'b0; end
            if (!DReqM && d_stim.size() != 0) begin
               a          = d_stim.pop_front();
               MemWriteM  = a.we;
               ALUOutM    = a.addr;
               WriteDataM = a.wdata;
               DReqM      = 1'b1;
               t0         = cyc;
               e.data     = exp_berr ? '0 : memval(a.addr);
               e.berr     = exp_berr;
               e.lat      = exp_lat;
               d_exp.push_back(e);
            end
         end
      end
   end

   // Bus monitor: grant order, field stability, one-cycle Ready, quiet data outputs.
   initial begin
      bit p_req, p_ir, p_dr, p_be;
      acc_t g, held;
      p_req = 1'b0; p_ir = 1'b0; p_dr = 1'b0; p_be = 1'b0;
      held = mk(1'b0, '0, '0);
      forever begin
         @(negedge clk);
         if (!IReadyF) check("InstrF_zero", InstrF, '0);
         if (!DReadyM) check("ReadDataM_zero", ReadDataM, '0);
         if (BusErr)   check("BusErr_ready", 32'(IReadyF | DReadyM), 32'd1);
         if (p_ir)     check("IReadyF_pulse", 32'(IReadyF), 32'd0);
         if (p_dr)     check("DReadyM_pulse", 32'(DReadyM), 32'd0);
         if (p_be)     check("req_after_abort", 32'(u_mem.mem_req), 32'd0);
         if (u_mem.mem_req && !p_req) begin
            check("grant_expected", 32'(g_exp.size() != 0), 32'd1);
            if (g_exp.size() != 0) begin
               g = g_exp.pop_front();
               check("grant_we", 32'(u_mem.mem_we), 32'(g.we));
               check("grant_addr", u_mem.mem_addr, g.addr);
               if (g.we) check("grant_wdata", u_mem.mem_wdata, g.wdata);
            end
            held = mk(u_mem.mem_we, u_mem.mem_addr, u_mem.mem_wdata);
         end else if (u_mem.mem_req) begin
            check("hold_we", 32'(u_mem.mem_we), 32'(held.we));
            check("hold_addr", u_mem.mem_addr, held.addr);
            check("hold_wdata", u_mem.mem_wdata, held.wdata);
         end
         p_req = u_mem.mem_req;
         p_ir  = IReadyF;
         p_dr  = DReadyM;
         p_be  = BusErr;
      end
   end

   task automatic drain(input string tag);
      int unsigned n;
      n = 0;
      while ((f_stim.size() != 0 || d_stim.size() != 0 || f_exp.size() != 0 ||
              d_exp.size() != 0 || IReqF || DReqM) && n < 300) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_drain"}, 32'(n < 300), 32'd1);
      check({tag, "_grants_left"}, 32'(g_exp.size()), 32'd0);
      #2;
   endtask

   initial begin
      int unsigned n;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_mem_req", 32'(u_mem.mem_req), 32'd0);
      check("rst_mem_we", 32'(u_mem.mem_we), 32'd0);
      check("rst_mem_addr", u_mem.mem_addr, '0);
      check("rst_mem_wdata", u_mem.mem_wdata, '0);
      check("rst_IReadyF", 32'(IReadyF), 32'd0);
      check("rst_DReadyM", 32'(DReadyM), 32'd0);
      check("rst_BusErr", 32'(BusErr), 32'd0);
      #2 reset = 1'b0;

      // Fetch only, ack in first busy cycle
      rsp_lat = 1; exp_lat = 2; exp_berr = 1'b0;
      g_exp.push_back(mk(1'b0, 32'h8, '0));
      f_stim.push_back(32'h8);
      drain("t1");

      // Simultaneous: store first, then fetch
      exp_lat = 0;
      g_exp.push_back(mk(1'b1, 32'h40, 32'h7));
      g_exp.push_back(mk(1'b0, 32'h100, '0));
      d_stim.push_back(mk(1'b1, 32'h40, 32'h7));
      f_stim.push_back(32'h100);
      drain("t2");

      // Fairness: four data grants bypass fetch, fifth goes to fetch
      for (int unsigned i = 0; i < 6; i++) begin
         d_stim.push_back(mk(1'b0, 32'h200 + 4 * i, '0));
         if (i < 4) g_exp.push_back(mk(1'b0, 32'h200 + 4 * i, '0));
      end
      g_exp.push_back(mk(1'b0, 32'h300, '0));
      g_exp.push_back(mk(1'b0, 32'h210, '0));
      g_exp.push_back(mk(1'b0, 32'h214, '0));
      f_stim.push_back(32'h300);
      drain("t3");

      // Fairness cleared by the fetch grant: data wins again
      g_exp.push_back(mk(1'b0, 32'h400, '0));
      g_exp.push_back(mk(1'b0, 32'h500, '0));
      d_stim.push_back(mk(1'b0, 32'h400, '0));
      f_stim.push_back(32'h500);
      drain("t3b");

      // Wait states: ack in the 4th busy cycle
      rsp_lat = 4; exp_lat = 5;
      g_exp.push_back(mk(1'b1, 32'h600, 32'hCAFE_F00D));
      d_stim.push_back(mk(1'b1, 32'h600, 32'hCAFE_F00D));
      drain("t4");

      // Timeout: no ack, abort in the 16th busy cycle
      rsp_lat = 0; exp_lat = TIMEOUT + 1; exp_berr = 1'b1;
      g_exp.push_back(mk(1'b0, 32'h700, '0));
      d_stim.push_back(mk(1'b0, 32'h700, '0));
      drain("t5");
      exp_berr = 1'b0;

      // Reset mid-access, then a late ack while idle
      exp_lat = 0;
      g_exp.push_back(mk(1'b0, 32'h800, '0));
      d_stim.push_back(mk(1'b0, 32'h800, '0));
      n = 0;
      while (!u_mem.mem_req && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("t6_req_seen", 32'(u_mem.mem_req), 32'd1);
      @(negedge clk);
      #2 reset = 1'b1;
      #1 check("t6_req_async", 32'(u_mem.mem_req), 32'd0);
      late_ack = 1'b1;
      @(negedge clk);
      check("t6_mem_we", 32'(u_mem.mem_we), 32'd0);
      check("t6_mem_addr", u_mem.mem_addr, '0);
      check("t6_mem_wdata", u_mem.mem_wdata, '0);
      check("t6_BusErr", 32'(BusErr), 32'd0);
      #2 reset = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check("t6_no_DReadyM", 32'(DReadyM), 32'd0);
         check("t6_no_IReadyF", 32'(IReadyF), 32'd0);
         check("t6_idle_req", 32'(u_mem.mem_req), 32'd0);
      end
      #2 late_ack = 1'b0;

      // Recovery after reset
      rsp_lat = 1; exp_lat = 2;
      g_exp.push_back(mk(1'b0, 32'h900, '0));
      f_stim.push_back(32'h900);
      drain("t7");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
